// File: rtl/pwm_multich.sv
// Multi-channel PWM generator with a shared prescaler and period counter.
// Timing registers are double-buffered: bus writes land in staging copies, the core runs on active copies.
module pwm_multich #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write_enable,
    input  logic              read_enable,
    input  logic [7:0]        address,
    input  logic [CNT_W-1:0]  writedata,
    output logic [CNT_W-1:0]  readdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_DIV    = 8'h01;
    localparam logic [7:0] ADDR_PERIOD = 8'h02;
    localparam logic [7:0] ADDR_STATUS = 8'h03;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              wr, rd;
    logic              glb_en, irq_en;
    logic [CNT_W-1:0]  divisor_stg, period_stg;
    logic [CNT_W-1:0]  divisor_act, period_act;
    logic [CNT_W-1:0]  duty_stg [NUM_CH];
    logic [CNT_W-1:0]  duty_act [NUM_CH];
    logic [NUM_CH-1:0] ch_en, ch_pol;
    logic [NUM_CH-1:0] duty_sel, chctrl_sel;
    logic [CNT_W-1:0]  prescale, count;
    logic              period_done;
    logic              update_req, clear_req, status_clr;
    logic              tick, wrap, load;
    logic [CNT_W-1:0]  rd_mux;

    assign wr = chipselect && write_enable;
    assign rd = chipselect && read_enable;

    assign update_req = wr && (address == ADDR_CTRL) && writedata[1];
    assign clear_req  = wr && (address == ADDR_CTRL) && writedata[2];
    assign status_clr = wr && (address == ADDR_STATUS) && writedata[0];

    // A clear pulse suppresses the wrap so it never counts as a finished period
    assign tick = glb_en && (prescale >= divisor_act);
    assign wrap = tick && !clear_req && (count >= period_act);
    assign load = wrap || update_req || !glb_en;

    assign irq = period_done && irq_en;

    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            duty_sel[n]   = (address == 8'(16 + 2 * n));
            chctrl_sel[n] = (address == 8'(17 + 2 * n));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glb_en      <= 1'b0;
            irq_en      <= 1'b0;
            divisor_stg <= '0;
            period_stg  <= '0;
            ch_en       <= '0;
            ch_pol      <= '0;
            for (int n = 0; n < NUM_CH; n++) duty_stg[n] <= '0;
        end else if (wr) begin
            case (address)
                ADDR_CTRL: begin
                    glb_en <= writedata[0];
                    irq_en <= writedata[3];
                end
                ADDR_DIV:    divisor_stg <= writedata;
                ADDR_PERIOD: period_stg  <= writedata;
                default: ;
            endcase
            for (int n = 0; n < NUM_CH; n++) begin
                if (duty_sel[n]) duty_stg[n] <= writedata;
                if (chctrl_sel[n]) begin
                    ch_en[n]  <= writedata[0];
                    ch_pol[n] <= writedata[1];
                end
            end
        end
    end

    // Loading from the pre-edge staging value means a write on a load edge waits for the next load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divisor_act <= '0;
            period_act  <= '0;
            for (int n = 0; n < NUM_CH; n++) duty_act[n] <= '0;
        end else if (load) begin
            divisor_act <= divisor_stg;
            period_act  <= period_stg;
            for (int n = 0; n < NUM_CH; n++) duty_act[n] <= duty_stg[n];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            count    <= '0;
        end else if (!glb_en || clear_req) begin
            prescale <= '0;
            count    <= '0;
        end else if (tick) begin
            prescale <= '0;
            count    <= wrap ? '0 : count + CNT_ONE;
        end else begin
            prescale <= prescale + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_done <= 1'b0;
        end else if (wrap) begin
            period_done <= 1'b1;
        end else if (status_clr) begin
            period_done <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_out <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (glb_en && ch_en[n]) pwm_out[n] <= (count < duty_act[n]) ^ ch_pol[n];
                else                    pwm_out[n] <= ch_pol[n];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_CTRL: begin
                rd_mux[0] = glb_en;
                rd_mux[3] = irq_en;
            end
            ADDR_DIV:    rd_mux = divisor_stg;
            ADDR_PERIOD: rd_mux = period_stg;
            ADDR_STATUS: rd_mux[0] = period_done;
            default: ;
        endcase
        for (int n = 0; n < NUM_CH; n++) begin
            if (duty_sel[n])   rd_mux = duty_stg[n];
            if (chctrl_sel[n]) rd_mux = {{(CNT_W-2){1'b0}}, ch_pol[n], ch_en[n]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) readdata <= '0;
        else       readdata <= rd ? rd_mux : '0;
    end

endmodule

// File: tb/tb_pwm_multich.sv
// Self-checking bench for pwm_multich: register table, directed timing sequences
// and randomized waveforms compared against an arithmetic period/duty model.
module tb_pwm_multich;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              chipselect = 1'b0;
    logic              write_enable = 1'b0;
    logic              read_enable = 1'b0;
    logic [7:0]        address = '0;
    logic [CNT_W-1:0]  writedata = '0;
    logic [CNT_W-1:0]  readdata;
    logic [NUM_CH-1:0] pwm_out;
    logic              irq;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rexp;
    } reg_vec_t;

    reg_vec_t vecs [11];

    always #5 clk = ~clk;

    pwm_multich #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .chipselect   (chipselect),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata),
        .pwm_out      (pwm_out),
        .irq          (irq)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // All bus helpers start and end on a falling edge, so inputs are stable across the rising edge
    task automatic bus_write(input logic [7:0] addr, input logic [15:0] data);
        chipselect   = 1'b1;
        write_enable = 1'b1;
        address      = addr;
        writedata    = data;
        @(negedge clk);
        chipselect   = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] addr, output logic [15:0] data);
        chipselect  = 1'b1;
        read_enable = 1'b1;
        address     = addr;
        @(negedge clk);
        chipselect  = 1'b0;
        read_enable = 1'b0;
        data        = readdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input reg_vec_t v);
        logic [15:0] rd;
        bus_write(v.addr, v.wdata);
        bus_read(v.addr, rd);
        checkOutput($sformatf("reg 0x%02h readback", v.addr), 32'(rd), 32'(v.rexp));
    endtask

    // Channel 0: PERIOD 9, DUTY 3, then DUTY 7 written on cycle w after enabling
    task automatic run_duty_change(input int w);
        int c, p, duty;
        do_reset();
        bus_write(8'h01, 16'd0);
        bus_write(8'h02, 16'd9);
        bus_write(8'h10, 16'd3);
        bus_write(8'h11, 16'd1);
        bus_write(8'h00, 16'd1);
        for (int m = 1; m <= 30; m++) begin
            if (m == w) bus_write(8'h10, 16'd7);
            else        @(negedge clk);
            c = (m - 1) % 10;
            p = (m - 1) / 10;
            duty = (w < 10 * p) ? 7 : 3;
            checkOutput($sformatf("duty w=%0d m=%0d", w, m), 32'(pwm_out[0]), 32'(c < duty));
        end
    endtask

    task automatic run_random(input int trial);
        int d, p, c;
        int duty [NUM_CH];
        logic [NUM_CH-1:0] pol, en, expv;
        do_reset();
        d = int'($urandom_range(0, 3));
        p = int'($urandom_range(0, 12));
        bus_write(8'h01, 16'(d));
        bus_write(8'h02, 16'(p));
        for (int n = 0; n < NUM_CH; n++) begin
            duty[n] = int'($urandom_range(0, p + 2));
            pol[n]  = 1'($urandom_range(0, 1));
            en[n]   = ($urandom_range(0, 3) != 0);
            bus_write(8'(16 + 2 * n), 16'(duty[n]));
        end
        for (int n = 0; n < NUM_CH; n++) bus_write(8'(17 + 2 * n), {14'd0, pol[n], en[n]});
        bus_write(8'h00, 16'd1);
        checkOutput($sformatf("rand%0d idle level", trial), 32'(pwm_out), 32'(pol));
        for (int m = 1; m <= 2 * (d + 1) * (p + 1) + 4; m++) begin
            @(negedge clk);
            c = ((m - 1) / (d + 1)) % (p + 1);
            for (int n = 0; n < NUM_CH; n++)
                expv[n] = en[n] ? ((c < duty[n]) ^ pol[n]) : pol[n];
            checkOutput($sformatf("rand%0d d=%0d p=%0d m=%0d", trial, d, p, m), 32'(pwm_out), 32'(expv));
        end
    endtask

    initial begin
        logic [15:0] rd;
        int c;

        vecs[0]  = '{8'h01, 16'hABCD, 16'hABCD};
        vecs[1]  = '{8'h02, 16'h1234, 16'h1234};
        vecs[2]  = '{8'h10, 16'h00FF, 16'h00FF};
        vecs[3]  = '{8'h11, 16'hFFFF, 16'h0003};
        vecs[4]  = '{8'h16, 16'h8001, 16'h8001};
        vecs[5]  = '{8'h17, 16'h0002, 16'h0002};
        vecs[6]  = '{8'h18, 16'hFFFF, 16'h0000};
        vecs[7]  = '{8'h05, 16'hFFFF, 16'h0000};
        vecs[8]  = '{8'h03, 16'hFFFF, 16'h0000};
        vecs[9]  = '{8'h00, 16'h000E, 16'h0008};
        vecs[10] = '{8'h00, 16'h0000, 16'h0000};

        @(negedge clk);
        checkOutput("reset pwm_out", 32'(pwm_out), 32'd0);
        checkOutput("reset irq", 32'(irq), 32'd0);
        checkOutput("reset readdata", 32'(readdata), 32'd0);
        do_reset();

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

        // Fixed duty, mid-period duty change, and a change landing on the wrap edge
        run_duty_change(1000);
        run_duty_change(5);
        run_duty_change(10);

        // Inverted channel 1: DUTY 0 gives constant high, DUTY above PERIOD gives constant low
        do_reset();
        bus_write(8'h01, 16'd1);
        bus_write(8'h02, 16'd3);
        bus_write(8'h12, 16'd0);
        bus_write(8'h13, 16'd3);
        bus_write(8'h00, 16'd1);
        for (int m = 1; m <= 16; m++) begin
            @(negedge clk);
            checkOutput($sformatf("duty0 inverted m=%0d", m), 32'(pwm_out[1]), 32'd1);
        end
        bus_write(8'h12, 16'd5);
        bus_write(8'h00, 16'd3);
        for (int m = 1; m <= 16; m++) begin
            @(negedge clk);
            checkOutput($sformatf("duty5 inverted m=%0d", m), 32'(pwm_out[1]), 32'd0);
        end

        // Interrupt: set on wrap, cleared by STATUS write, set wins over clear on a wrap edge
        do_reset();
        bus_write(8'h01, 16'd0);
        bus_write(8'h02, 16'd4);
        bus_write(8'h00, 16'd9);
        for (int m = 1; m <= 12; m++) begin
            if (m == 7 || m == 10 || m == 12) bus_write(8'h03, 16'd1);
            else                              @(negedge clk);
            checkOutput($sformatf("irq m=%0d", m), 32'(irq),
                        32'((m >= 5 && m <= 6) || (m >= 10 && m <= 11)));
        end

        // Counter clear mid-period restarts the period without flagging period_done
        do_reset();
        bus_write(8'h01, 16'd0);
        bus_write(8'h02, 16'd9);
        bus_write(8'h10, 16'd3);
        bus_write(8'h11, 16'd1);
        bus_write(8'h00, 16'd9);
        for (int m = 1; m <= 17; m++) begin
            if (m == 5) bus_write(8'h00, 16'hD);
            else        @(negedge clk);
            c = (m <= 5) ? (m - 1) : ((m - 6) % 10);
            checkOutput($sformatf("clear pwm m=%0d", m), 32'(pwm_out[0]), 32'(c < 3));
            checkOutput($sformatf("clear irq m=%0d", m), 32'(irq), 32'(m >= 15));
        end

        // Read timing: data one cycle after the strobe, zero otherwise
        do_reset();
        bus_write(8'h02, 16'h1234);
        checkOutput("readdata idle", 32'(readdata), 32'd0);
        bus_read(8'h02, rd);
        checkOutput("read period", 32'(rd), 32'h1234);
        @(negedge clk);
        checkOutput("readdata after read", 32'(readdata), 32'd0);
        bus_read(8'h55, rd);
        checkOutput("read unmapped", 32'(rd), 32'd0);
        read_enable = 1'b1;
        address     = 8'h02;
        @(negedge clk);
        read_enable = 1'b0;
        checkOutput("read without chipselect", 32'(readdata), 32'd0);

        // Asynchronous reset at count 5 with outputs and readdata active
        do_reset();
        bus_write(8'h01, 16'd0);
        bus_write(8'h02, 16'd9);
        bus_write(8'h10, 16'd7);
        bus_write(8'h11, 16'd1);
        bus_write(8'h00, 16'd9);
        repeat (14) @(negedge clk);
        bus_read(8'h02, rd);
        checkOutput("pre-reset readdata", 32'(rd), 32'd9);
        checkOutput("pre-reset pwm_out", 32'(pwm_out), 32'd1);
        checkOutput("pre-reset irq", 32'(irq), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset pwm_out", 32'(pwm_out), 32'd0);
        checkOutput("async reset irq", 32'(irq), 32'd0);
        checkOutput("async reset readdata", 32'(readdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int m = 1; m <= 20; m++) begin
            @(negedge clk);
            checkOutput($sformatf("post-reset pwm m=%0d", m), 32'(pwm_out), 32'd0);
            checkOutput($sformatf("post-reset irq m=%0d", m), 32'(irq), 32'd0);
        end
        bus_read(8'h00, rd);
        checkOutput("post-reset ctrl", 32'(rd), 32'd0);
        bus_read(8'h02, rd);
        checkOutput("post-reset period", 32'(rd), 32'd0);
        bus_read(8'h10, rd);
        checkOutput("post-reset duty0", 32'(rd), 32'd0);

        for (int t = 0; t < 6; t++) run_random(t);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
